uart_ctrl: RTL and testbench

//   Serial UART peripheral behind the data memory's MMIO window (TXD 0x40000018, RXD 0x4000001C, CON 0x40000020).

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_core.sv | 101 ++++++++++
 rtl/uart_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encodings, MMIO addresses and status bit indices
//               for the UART peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_BUSY  = 0;
  localparam int CON_RX_BUSY  = 1;
  localparam int CON_TX_DONE  = 2;
  localparam int CON_RX_DONE  = 3;
  localparam int CON_RX_OVERR = 4;

  // Tick count at which a bit period ends, and the start-bit mid-point.
  localparam logic [3:0] TICK_LAST = 4'd15;
  localparam logic [3:0] TICK_MID  = 4'd7;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 16x oversampled 8N1 receiver with input synchroniser.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       rx_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [7:0] byte_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  rx_state_e  state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       rx_s;

  assign rx_s   = sync_q[1];
  assign busy_o = (state_q != RX_IDLE);
  assign byte_o = shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      tcnt_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = RX_START;
          tcnt_d  = 4'd0;
        end
      end
      RX_START: begin
        // Half a bit in: a line that has gone high again was only a glitch.
        if (tick_i) begin
          if (tcnt_q == TICK_MID) begin
            tcnt_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick_i) begin
          if (tcnt_q == TICK_LAST) begin
            tcnt_d  = 4'd0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RX_STOP;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick_i) begin
          if (tcnt_q == TICK_LAST) begin
            state_d = RX_IDLE;
            valid_o = rx_s;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl
// Description : MMIO UART peripheral: tick generator, 8N1 transmitter,
//               receiver instance and sticky status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       con_read,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_data,
  output logic [4:0] uart_con,
  output logic       irq
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_q <= '0;
    else               div_q <= div_q + 1'b1;
  end

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_line_q, tx_line_d;
  logic       tx_done_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_tcnt_d   = tx_tcnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_tcnt_d  = 4'd0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_tcnt_q == TICK_LAST) begin
            tx_tcnt_d  = 4'd0;
            tx_bit_d   = 3'd0;
            tx_state_d = TX_DATA;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tcnt_q == TICK_LAST) begin
            tx_tcnt_d  = 4'd0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
      TX_STOP: begin
        // A write landing on the final stop cycle starts the next frame directly.
        if (tick) begin
          if (tx_tcnt_q == TICK_LAST) begin
            tx_done_set = 1'b1;
            tx_tcnt_d   = 4'd0;
            if (tx_start) begin
              tx_state_d = TX_START;
              tx_shift_d = tx_data;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_line_q;

  logic       rx_busy;
  logic       rx_valid;
  logic [7:0] rx_byte;

  uart_rx_core u_rx_core (
    .clk     (clk),
    .reset   (reset),
    .tick_i  (tick),
    .rx_i    (uart_rx),
    .busy_o  (rx_busy),
    .valid_o (rx_valid),
    .byte_o  (rx_byte)
  );

  logic       tx_done_q, rx_done_q, overrun_q;
  logic [7:0] rx_data_q;

  // Set events take priority over a coincident status read.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      overrun_q <= 1'b0;
      rx_data_q <= 8'd0;
    end else begin
      if (tx_done_set)   tx_done_q <= 1'b1;
      else if (con_read) tx_done_q <= 1'b0;

      if (rx_valid)      rx_done_q <= 1'b1;
      else if (con_read) rx_done_q <= 1'b0;

      if (rx_valid && rx_done_q) overrun_q <= 1'b1;
      else if (con_read)         overrun_q <= 1'b0;

      if (rx_valid) rx_data_q <= rx_byte;
    end
  end

  always_comb begin
    uart_con               = 5'd0;
    uart_con[CON_TX_BUSY]  = (tx_state_q != TX_IDLE);
    uart_con[CON_RX_BUSY]  = rx_busy;
    uart_con[CON_TX_DONE]  = tx_done_q;
    uart_con[CON_RX_DONE]  = rx_done_q;
    uart_con[CON_RX_OVERR] = overrun_q;
  end

  assign rx_data = rx_data_q;
  assign irq     = tx_done_q | rx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ctrl
// Description : Self-checking bench for uart_ctrl at 16 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_start = 1'b0;
  logic       con_read = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [7:0] rx_data;
  logic [4:0] uart_con;
  logic       irq;

  uart_ctrl #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .con_read (con_read),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .rx_data  (rx_data),
    .uart_con (uart_con),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a TX frame is 160 clocks (start, 8 data LSB first, stop);
  // received bytes are posted by the stimulus once a frame has fully passed.
  logic       m_valid = 1'b0;
  logic       m_tx_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'd0;
  logic       m_tx_done = 1'b0, m_rx_done = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_rx_data = 8'd0;
  int         ev_req = 0, ev_ack = 0;
  logic [7:0] ev_byte = 8'd0;
  logic       ev_good = 1'b0;
  logic       rx_known = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_tx_act = 1'b0; m_pos = 0;
      m_tx_done = 1'b0; m_rx_done = 1'b0; m_ovr = 1'b0; m_rx_data = 8'd0;
      ev_ack = ev_req;
    end else begin
      if (con_read) begin
        m_tx_done = 1'b0; m_rx_done = 1'b0; m_ovr = 1'b0;
      end
      if (m_tx_act) begin
        if (m_pos == 159) begin
          m_tx_act = 1'b0; m_tx_done = 1'b1;
        end else begin
          m_pos++;
        end
      end
      if (tx_start && !m_tx_act) begin
        m_tx_act = 1'b1; m_pos = 0; m_byte = tx_data;
      end
      if (ev_req != ev_ack) begin
        ev_ack = ev_req;
        if (ev_good) begin
          if (m_rx_done) m_ovr = 1'b1;
          m_rx_done = 1'b1;
          m_rx_data = ev_byte;
        end
      end
    end
  end

  function automatic logic exp_line();
    int idx;
    if (!m_tx_act) return 1'b1;
    if (m_pos < 16) return 1'b0;
    if (m_pos >= 144) return 1'b1;
    idx = (m_pos - 16) / 16;
    return m_byte[idx];
  endfunction

  always @(negedge clk) begin
    if (m_valid && !reset) begin
      chk("uart_tx", {31'd0, uart_tx}, {31'd0, exp_line()});
      chk("tx_busy", {31'd0, uart_con[0]}, {31'd0, m_tx_act});
      chk("tx_done", {31'd0, uart_con[2]}, {31'd0, m_tx_done});
      if (rx_known) begin
        chk("rx_busy", {31'd0, uart_con[1]}, 32'd0);
        chk("rx_done", {31'd0, uart_con[3]}, {31'd0, m_rx_done});
        chk("rx_overrun", {31'd0, uart_con[4]}, {31'd0, m_ovr});
        chk("rx_data", {24'd0, rx_data}, {24'd0, m_rx_data});
        chk("irq", {31'd0, irq}, {31'd0, m_tx_done | m_rx_done});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx_known = 1'b0;
    uart_rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (16) tick();
    end
    uart_rx = stop_bit;
    repeat (16) tick();
    uart_rx = 1'b1;
    repeat (4) tick();
    ev_byte = b; ev_good = stop_bit; ev_req++;
    tick();
    rx_known = 1'b1;
  endtask

  task automatic pulse_con_read();
    con_read = 1'b1;
    tick();
    con_read = 1'b0;
  endtask

  logic [9:0] a5_line = 10'b11_0100_1010;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_con", {27'd0, uart_con}, 32'd0);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // 1) transmit 0xA5; mid-bit samples pinned against a literal line pattern
    tx_data = 8'hA5; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      repeat (8) tick();
      chk("s1_line_bit", {31'd0, uart_tx}, {31'd0, a5_line[b]});
      chk("s1_busy", {31'd0, uart_con[0]}, 32'd1);
      repeat (8) tick();
    end
    chk("s1_con_after", {27'd0, uart_con}, 32'b00100);
    chk("s1_irq_after", {31'd0, irq}, 32'd1);
    pulse_con_read();

    // 2) receive 0x3C, then read status
    send_rx(8'h3C, 1'b1);
    chk("s2_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("s2_rx_done", {31'd0, uart_con[3]}, 32'd1);
    chk("s2_irq", {31'd0, irq}, 32'd1);
    pulse_con_read();
    chk("s2_con_cleared", {27'd0, uart_con}, 32'd0);
    chk("s2_irq_cleared", {31'd0, irq}, 32'd0);

    // 3) false start
    rx_known = 1'b0;
    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (30) tick();
    rx_known = 1'b1;
    chk("s3_rx_data", {24'd0, rx_data}, 32'h3C);
    chk("s3_rx_done", {31'd0, uart_con[3]}, 32'd0);
    chk("s3_rx_busy", {31'd0, uart_con[1]}, 32'd0);

    // 4) overrun, then a framing error
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    chk("s4_rx_data", {24'd0, rx_data}, 32'h22);
    chk("s4_flags", {30'd0, uart_con[4:3]}, 32'b11);
    send_rx(8'h99, 1'b0);
    repeat (20) tick();
    chk("s4_framing_rx_data", {24'd0, rx_data}, 32'h22);
    pulse_con_read();

    // 6) status read coinciding with stop-bit acceptance: set wins
    k = 0;
    fork
      send_rx(8'h6B, 1'b1);
      begin
        repeat (146) tick();
        con_read = uart_con[1];
        while (con_read && k < 40) begin
          tick();
          k++;
          con_read = uart_con[1];
        end
        con_read = 1'b0;
      end
    join
    chk("s6_window_hit", {31'd0, (k > 0 && k < 40)}, 32'd1);
    chk("s6_rx_done", {31'd0, uart_con[3]}, 32'd1);
    chk("s6_rx_data", {24'd0, rx_data}, 32'h6B);
    pulse_con_read();

    // 5) write while busy is ignored; reset mid-frame
    tx_data = 8'h55; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    repeat (39) tick();
    tx_data = 8'hFF; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data = 8'h00;
    repeat (7) tick();
    chk("s5_bit1_of_55", {31'd0, uart_tx}, 32'd0);
    repeat (32) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_reset_tx", {31'd0, uart_tx}, 32'd1);
    chk("s5_reset_con", {27'd0, uart_con}, 32'd0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
